// File: rtl/frv_asi_arb.sv
// Round-robin arbiter/sequencer in front of the shared algorithm-specific instruction unit.
// Holds the grant until completion, and flushes AES state after an abandon or timeout.
module frv_asi_arb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned OPW     = 7,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            g_clk,
  input  logic            g_reset,

  input  logic            rq0_valid,
  input  logic [OPW-1:0]  rq0_uop,
  input  logic [XLEN-1:0] rq0_rs1,
  input  logic [XLEN-1:0] rq0_rs2,
  input  logic [1:0]      rq0_shamt,
  output logic            rq0_ready,
  output logic            rq0_err,
  output logic [XLEN-1:0] rq0_result,

  input  logic            rq1_valid,
  input  logic [OPW-1:0]  rq1_uop,
  input  logic [XLEN-1:0] rq1_rs1,
  input  logic [XLEN-1:0] rq1_rs2,
  input  logic [1:0]      rq1_shamt,
  output logic            rq1_ready,
  output logic            rq1_err,
  output logic [XLEN-1:0] rq1_result,

  output logic            asi_valid,
  output logic [OPW-1:0]  asi_uop,
  output logic [XLEN-1:0] asi_rs1,
  output logic [XLEN-1:0] asi_rs2,
  output logic [1:0]      asi_shamt,
  input  logic            asi_ready,
  input  logic [XLEN-1:0] asi_result,
  output logic            asi_flush_aessub,
  output logic            asi_flush_aesmix,
  output logic [31:0]     asi_flush_data
);

  typedef enum logic [1:0] {StIdle, StBusy, StFlush} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       own_valid;

  assign own_valid      = owner_q ? rq1_valid : rq0_valid;
  assign asi_flush_data = 32'h0;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // requester 0 wins the first tie
      tcnt_q  <= 8'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_d           = last_q;
    tcnt_d           = tcnt_q;
    asi_valid        = 1'b0;
    asi_uop          = '0;
    asi_rs1          = '0;
    asi_rs2          = '0;
    asi_shamt        = '0;
    asi_flush_aessub = 1'b0;
    asi_flush_aesmix = 1'b0;
    rq0_ready        = 1'b0;
    rq0_err          = 1'b0;
    rq0_result       = '0;
    rq1_ready        = 1'b0;
    rq1_err          = 1'b0;
    rq1_result       = '0;

    case (state_q)
      StIdle: begin
        tcnt_d = 8'h0;
        if (rq0_valid || rq1_valid) begin
          state_d = StBusy;
          owner_d = (rq0_valid && rq1_valid) ? ~last_q : rq1_valid;
        end
      end

      StBusy: begin
        asi_valid = 1'b1;
        asi_uop   = owner_q ? rq1_uop   : rq0_uop;
        asi_rs1   = owner_q ? rq1_rs1   : rq0_rs1;
        asi_rs2   = owner_q ? rq1_rs2   : rq0_rs2;
        asi_shamt = owner_q ? rq1_shamt : rq0_shamt;
        // Completion beats abandon, which beats timeout.
        if (asi_ready) begin
          if (owner_q) begin
            rq1_ready  = 1'b1;
            rq1_result = asi_result;
          end else begin
            rq0_ready  = 1'b1;
            rq0_result = asi_result;
          end
          last_d  = owner_q;
          state_d = StIdle;
        end else if (!own_valid) begin
          state_d = StFlush;
        end else if (tcnt_q == TimeoutCnt) begin
          if (owner_q) rq1_err = 1'b1;
          else         rq0_err = 1'b1;
          last_d  = owner_q;
          state_d = StFlush;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      StFlush: begin
        asi_flush_aessub = 1'b1;
        asi_flush_aesmix = 1'b1;
        state_d          = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_frv_asi_arb.sv
// Directed bench for frv_asi_arb: inputs change 1 time unit after each rising edge,
// outputs are sampled 2 units later in the same cycle.
module tb_frv_asi_arb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 7;

  logic            g_clk, g_reset;
  logic            rq0_valid, rq1_valid;
  logic [OPW-1:0]  rq0_uop, rq1_uop;
  logic [XLEN-1:0] rq0_rs1, rq0_rs2, rq1_rs1, rq1_rs2;
  logic [1:0]      rq0_shamt, rq1_shamt;
  logic            rq0_ready, rq1_ready, rq0_err, rq1_err;
  logic [XLEN-1:0] rq0_result, rq1_result;
  logic            asi_valid, asi_ready;
  logic [OPW-1:0]  asi_uop;
  logic [XLEN-1:0] asi_rs1, asi_rs2, asi_result;
  logic [1:0]      asi_shamt;
  logic            asi_flush_aessub, asi_flush_aesmix;
  logic [31:0]     asi_flush_data;

  int total = 0;
  int bad   = 0;

  frv_asi_arb #(.XLEN(XLEN), .OPW(OPW), .TIMEOUT(4)) dut (
    .g_clk            (g_clk),
    .g_reset          (g_reset),
    .rq0_valid        (rq0_valid),
    .rq0_uop          (rq0_uop),
    .rq0_rs1          (rq0_rs1),
    .rq0_rs2          (rq0_rs2),
    .rq0_shamt        (rq0_shamt),
    .rq0_ready        (rq0_ready),
    .rq0_err          (rq0_err),
    .rq0_result       (rq0_result),
    .rq1_valid        (rq1_valid),
    .rq1_uop          (rq1_uop),
    .rq1_rs1          (rq1_rs1),
    .rq1_rs2          (rq1_rs2),
    .rq1_shamt        (rq1_shamt),
    .rq1_ready        (rq1_ready),
    .rq1_err          (rq1_err),
    .rq1_result       (rq1_result),
    .asi_valid        (asi_valid),
    .asi_uop          (asi_uop),
    .asi_rs1          (asi_rs1),
    .asi_rs2          (asi_rs2),
    .asi_shamt        (asi_shamt),
    .asi_ready        (asi_ready),
    .asi_result       (asi_result),
    .asi_flush_aessub (asi_flush_aessub),
    .asi_flush_aesmix (asi_flush_aesmix),
    .asi_flush_data   (asi_flush_data)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Every output of the block packed into a few words; all must be zero.
  task automatic check_quiet(input string tag);
    check({tag, ".ctl"}, {24'h0, asi_valid, asi_flush_aessub, asi_flush_aesmix,
                          rq0_ready, rq0_err, rq1_ready, rq1_err, 1'b0}, 32'h0);
    check({tag, ".uop"}, {23'h0, asi_shamt, asi_uop}, 32'h0);
    check({tag, ".rs"}, asi_rs1 | asi_rs2, 32'h0);
    check({tag, ".res"}, rq0_result | rq1_result | asi_flush_data, 32'h0);
  endtask

  initial begin
    g_reset = 1'b1;
    rq0_valid = 1'b0; rq0_uop = '0; rq0_rs1 = '0; rq0_rs2 = '0; rq0_shamt = '0;
    rq1_valid = 1'b0; rq1_uop = '0; rq1_rs1 = '0; rq1_rs2 = '0; rq1_shamt = '0;
    asi_ready = 1'b0; asi_result = '0;
    tick();
    tick();
    g_reset = 1'b0;
    settle();
    check_quiet("reset");

    // Simultaneous requests after reset, unit always ready.
    tick();
    rq0_valid = 1'b1; rq0_uop = 7'h10; rq0_rs1 = 32'hA0A0_0001; rq0_rs2 = 32'hB0B0_0002;
    rq0_shamt = 2'd0;
    rq1_valid = 1'b1; rq1_uop = 7'h22; rq1_rs1 = 32'hC0C0_0003; rq1_rs2 = 32'hD0D0_0004;
    rq1_shamt = 2'd2;
    asi_ready = 1'b1; asi_result = 32'h1234_5678;
    settle();
    check("sim.c0.valid", asi_valid, 0);
    check("sim.c0.rdy0", rq0_ready, 0);
    tick();
    settle();
    check("sim.c1.valid", asi_valid, 1);
    check("sim.c1.uop", asi_uop, 7'h10);
    check("sim.c1.rs1", asi_rs1, 32'hA0A0_0001);
    check("sim.c1.rs2", asi_rs2, 32'hB0B0_0002);
    check("sim.c1.rdy0", rq0_ready, 1);
    check("sim.c1.res0", rq0_result, 32'h1234_5678);
    check("sim.c1.rdy1", rq1_ready, 0);
    check("sim.c1.res1", rq1_result, 0);
    tick();
    rq0_valid = 1'b0;
    settle();
    check("sim.c2.valid", asi_valid, 0);
    check("sim.c2.rdy1", rq1_ready, 0);
    tick();
    asi_result = 32'h8765_4321;
    settle();
    check("sim.c3.uop", asi_uop, 7'h22);
    check("sim.c3.shamt", asi_shamt, 2);
    check("sim.c3.rdy1", rq1_ready, 1);
    check("sim.c3.res1", rq1_result, 32'h8765_4321);
    check("sim.c3.rdy0", rq0_ready, 0);

    // Continuous contention: last served was 1, so grants go 0,1,0,1...
    tick();
    rq0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("cont.idle", asi_valid, 0);
      tick();
      settle();
      check("cont.uop", asi_uop, (i % 2 == 0) ? 7'h10 : 7'h22);
      check("cont.rdy0", rq0_ready, (i % 2 == 0) ? 1 : 0);
      check("cont.rdy1", rq1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    rq0_valid = 1'b0; rq1_valid = 1'b0; asi_ready = 1'b0;
    settle();
    check_quiet("cont.end");

    // Multi-cycle op: three stalled BUSY cycles, then completion.
    tick();
    rq0_valid = 1'b1; rq0_uop = 7'h31; rq0_rs1 = 32'hE0E0_0005; rq0_rs2 = 32'hF0F0_0006;
    rq0_shamt = 2'd1;
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("multi.valid", asi_valid, 1);
      check("multi.rs1", asi_rs1, 32'hE0E0_0005);
      check("multi.rs2", asi_rs2, 32'hF0F0_0006);
      check("multi.shamt", asi_shamt, 1);
      check("multi.stall", {rq0_ready, rq0_err}, 0);
      tick();
    end
    asi_ready = 1'b1; asi_result = 32'h0BAD_F00D;
    settle();
    check("multi.rdy0", rq0_ready, 1);
    check("multi.err0", rq0_err, 0);
    check("multi.res0", rq0_result, 32'h0BAD_F00D);
    tick();
    rq0_valid = 1'b0; asi_ready = 1'b0;
    settle();
    check_quiet("multi.after");

    // Abandon: rq1 drops valid in BUSY cycle 2.
    tick();
    rq1_valid = 1'b1; rq1_uop = 7'h05;
    tick();
    settle();
    check("abn.b1.valid", asi_valid, 1);
    check("abn.b1.uop", asi_uop, 7'h05);
    tick();
    rq1_valid = 1'b0;
    settle();
    check("abn.b2.pulses", {rq1_ready, rq1_err, asi_flush_aessub}, 0);
    tick();
    settle();
    check("abn.fl.valid", asi_valid, 0);
    check("abn.fl.sub", asi_flush_aessub, 1);
    check("abn.fl.mix", asi_flush_aesmix, 1);
    check("abn.fl.data", asi_flush_data, 0);
    check("abn.fl.pulses", {rq0_ready, rq0_err, rq1_ready, rq1_err}, 0);
    tick();
    settle();
    check_quiet("abn.idle");

    // Timeout: rq0 stuck for TIMEOUT=4, rq1 arrives meanwhile.
    tick();
    rq0_valid = 1'b1; rq0_uop = 7'h33;
    tick();
    rq1_valid = 1'b1; rq1_uop = 7'h44;
    for (int i = 1; i <= 4; i++) begin
      settle();
      check("tmo.uop", asi_uop, 7'h33);
      check("tmo.noerr", {rq0_err, rq1_err}, 0);
      tick();
    end
    settle();
    check("tmo.b5.err0", rq0_err, 1);
    check("tmo.b5.err1", rq1_err, 0);
    check("tmo.b5.rdy", {rq0_ready, rq1_ready}, 0);
    tick();
    rq0_valid = 1'b0;
    settle();
    check("tmo.fl", {asi_valid, asi_flush_aessub, asi_flush_aesmix}, 3'b011);
    check("tmo.fl.err", {rq0_err, rq1_err}, 0);
    tick();
    settle();
    check("tmo.idle.valid", asi_valid, 0);
    tick();
    asi_ready = 1'b1; asi_result = 32'h5555_AAAA;
    settle();
    check("tmo.g1.uop", asi_uop, 7'h44);
    check("tmo.g1.rdy1", rq1_ready, 1);
    check("tmo.g1.res1", rq1_result, 32'h5555_AAAA);
    tick();
    rq1_valid = 1'b0; asi_ready = 1'b0;

    // Precedence: completion and dropped valid together -> ready, no flush.
    tick();
    rq0_valid = 1'b1; rq0_uop = 7'h12;
    tick();
    rq0_valid = 1'b0; asi_ready = 1'b1; asi_result = 32'hCAFE_0001;
    settle();
    check("prec.rdy0", rq0_ready, 1);
    check("prec.res0", rq0_result, 32'hCAFE_0001);
    check("prec.flush", asi_flush_aessub, 0);
    tick();
    settle();
    // asi_ready still high here, outside BUSY: must be ignored.
    check_quiet("prec.next");
    tick();
    asi_ready = 1'b0;

    // Reset during BUSY.
    rq1_valid = 1'b1; rq1_uop = 7'h66; rq1_rs1 = 32'h7777_0007;
    tick();
    settle();
    check("rst.busy", asi_valid, 1);
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0; rq1_valid = 1'b0;
    settle();
    check_quiet("rst.after");
    tick();
    settle();
    check_quiet("rst.after2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frv_asi_arb.md
# frv_asi_arb

Two-port arbiter and sequencer for the shared algorithm-specific instruction unit (AES sub/mix, SHA2, SHA3). It sits between two requesters and the unit's `asi_*` port:

- **Requester 0:** the core execute stage.
- **Requester 1:** a background crypto engine.

The block grants the unit to one requester at a time using round-robin priority, and holds the grant until the operation completes. It flushes the unit's internal AES state when an operation is abandoned or times out.

## Interface

Parameters:
- `XLEN`, 32: operand/result width.
- `OPW`, 7: micro-op width, matching the unit's `asi_uop`.
- `TIMEOUT`, 15: maximum BUSY cycles without `asi_ready` before a forced abort (1..255).

Ports:
- `g_clk`  in  1  single clock; all state updates on the rising edge.
- `g_reset`  in  1  synchronous, active-high reset.
- `rq0_valid`, `rq1_valid`  in  1  request pending; held until `rqN_ready` or `rqN_err`.
- `rq0_uop`, `rq1_uop`  in  OPW  micro-op.
- `rq0_rs1`, `rq0_rs2`, `rq1_rs1`, `rq1_rs2`  in  XLEN  source operands.
- `rq0_shamt`, `rq1_shamt`  in  2  SHA3 shift amount.
- `rq0_ready`, `rq1_ready`  out  1  one-cycle completion pulse.
- `rq0_err`, `rq1_err`  out  1  one-cycle timeout-abort pulse.
- `rq0_result`, `rq1_result`  out  XLEN  result; valid only while `rqN_ready`=1, otherwise 0.
- `asi_valid`  out  1  operation valid to the unit.
- `asi_uop`  out  OPW  owner's `uop`; 0 when not BUSY.
- `asi_rs1`, `asi_rs2`  out  XLEN  owner's operands; 0 when not BUSY.
- `asi_shamt`  out  2  owner's `shamt`; 0 when not BUSY.
- `asi_ready`  in  1  unit completion.
- `asi_result`  in  XLEN  unit result.
- `asi_flush_aessub`, `asi_flush_aesmix`  out  1  flush strobes.
- `asi_flush_data`  out  32  flush data; constant 0.

## Operation

- **State:**
  - `state`: one of IDLE, BUSY, FLUSH.
  - `owner`: 1 bit.
  - `last`: 1 bit, the last owner served.
  - `tcnt`: 8-bit timeout counter.
- **Reset:**
  - `state`=IDLE, `owner`=0, `last`=1 (so requester 0 wins the first tie), `tcnt`=0.
  - All outputs are 0.
- **IDLE:**
  - No request: stay in IDLE.
  - One requester valid: `owner` := that requester, go to BUSY.
  - Both valid: `owner` := `!last`, go to BUSY.
  - `tcnt` := 0.
- **BUSY:**
  - `asi_valid`=1. `asi_uop`, `asi_rs1`, `asi_rs2` and `asi_shamt` are a combinational mux of the owner's inputs.
  - Completion (`asi_ready`=1 this cycle):
    - `rq[owner]_ready`=1 and `rq[owner]_result`=`asi_result`, both combinational in the same cycle.
    - `last` := `owner`, go to IDLE.
  - Abandon (owner's `valid`=0 with `asi_ready`=0): go to FLUSH; no `ready` or `err` pulse.
  - Timeout (`tcnt`==`TIMEOUT` with `asi_ready`=0):
    - `rq[owner]_err`=1 this cycle.
    - `last` := `owner`, go to FLUSH.
  - Otherwise: `tcnt` += 1.
  - Precedence: completion > abandon > timeout. `asi_ready` wins even when the owner's `valid` has dropped.
- **FLUSH:**
  - `asi_valid`=0; `asi_flush_aessub`=`asi_flush_aesmix`=1 for exactly one cycle.
  - Go to IDLE unconditionally.
- **Isolation:** the non-owner's `ready` and `err` are never asserted. `asi_ready` outside BUSY is ignored.
- **Reset mid-operation:** returns to IDLE next edge with no flush pulse and no `ready`/`err` pulse.

## Timing

- Arbitration latency: request seen in IDLE at cycle t → `asi_valid` at t+1.
- Single-cycle unit ops (SHA2, SHA3, fast AES) complete at t+1.
- Minimum request-to-`ready` latency is 1 cycle. Peak throughput is one operation per 2 cycles, because the FSM always returns to IDLE.
- A requester sees `ready` and then may present a new op on the next cycle. That op is granted one cycle later.
- Timeout: `err` is asserted in BUSY cycle `TIMEOUT`+1, then FLUSH for 1 cycle, then IDLE.
- Both requesters are served at least once every 2 grants. Worst-case wait is (`TIMEOUT`+3) cycles plus one's own op.

## Test plan

- **Simultaneous requests after reset:** after reset, `rq0` SHA2 op and `rq1` SHA3 op are presented together, with `asi_ready` tied 1.
  - `rq0_ready` at cycle 1, with `rq0_result`=`asi_result`.
  - `rq1_ready` at cycle 3. `rq1_result` is 0 at cycle 1.
- **Continuous contention:** both requesters stay valid for 8 ops → grants alternate 0,1,0,1…, with one IDLE cycle between grants.
- **Multi-cycle op:** `asi_ready` is held 0 for 3 BUSY cycles, then pulses.
  - Operands are stable on `asi_*` throughout.
  - Exactly one `rq0_ready` pulse; `tcnt` does not fire.
- **Abandon:** `rq1` drops `valid` in BUSY cycle 2 with `asi_ready`=0.
  - One-cycle FLUSH with both flush strobes =1 and `asi_flush_data`=0.
  - No `ready` or `err` pulse; back to IDLE.
- **Timeout:** `TIMEOUT`=4 and `asi_ready` stuck at 0.
  - `rq0_err` in BUSY cycle 5, then FLUSH, then `rq1` (pending) is granted next.
- **Precedence and reset:**
  - `asi_ready` and owner `valid`=0 in the same cycle → `ready` pulse, no FLUSH.
  - `g_reset` asserted in BUSY → IDLE next cycle, with all outputs 0 and no flush.
